// File: rtl/mips_pkg.sv
// Shared pipeline definitions: control-word bit positions, access size codes,
// bubble control value and MEM-stage FSM encoding.
package mips_pkg;

  localparam int unsigned CtrlBubble   = 0;
  localparam int unsigned CtrlMemRead  = 1;
  localparam int unsigned CtrlMemWrite = 2;
  localparam int unsigned CtrlRegWrite = 3;
  localparam int unsigned CtrlMemToReg = 4;
  localparam int unsigned CtrlLink     = 5;
  localparam int unsigned CtrlSizeLo   = 6;
  localparam int unsigned CtrlSizeHi   = 7;

  typedef enum logic [1:0] {
    SizeWord  = 2'b00,
    SizeByteS = 2'b01,
    SizeByteU = 2'b10,
    SizeWordA = 2'b11
  } size_e;

  localparam logic [7:0] BubbleCtrl = 8'h01;

  typedef enum logic {
    StIdle,
    StBusy
  } state_e;

  function automatic logic is_byte_size(input logic [1:0] size);
    return (size == SizeByteS) || (size == SizeByteU);
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
module mem_align
  import mips_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data
);

  logic [7:0] byte_sel;

  always_comb begin
    wdata     = store_data;
    be        = 4'hF;
    load_data = rdata;
    byte_sel  = rdata[{lane, 3'b000} +: 8];
    if (is_byte_size(size)) begin
      // Replicate the byte on all lanes; the byte enable picks the live one.
      wdata     = {4{store_data[7:0]}};
      be        = 4'b0001 << lane;
      load_data = (size == SizeByteS) ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory accesses over a req/ack bus, stalls the front
// pipeline while an access is outstanding, and drives the MEM/WB register.
module mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter logic [7:0]  BUBBLE_CTRL = BubbleCtrl
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        control_in,
  input  logic [31:0]       pc_4_in,
  input  logic [31:0]       alu_in,
  input  logic [31:0]       sw_in,
  input  logic [4:0]        regdst_in,
  output logic              stall_out,
  output logic              misalign_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic [7:0]        wb_control_out,
  output logic [31:0]       wb_data_out,
  output logic [4:0]        wb_regdst_out
);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              misalign_q, misalign_d;
  logic [7:0]        ctrl_q, ctrl_d;
  logic [4:0]        regdst_q, regdst_d;
  logic [31:0]       alu_q, alu_d;
  logic [7:0]        wb_ctrl_q, wb_ctrl_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic [4:0]        wb_regdst_q, wb_regdst_d;

  logic        mem_op, misaligned, busy;
  logic [1:0]  align_size, align_lane;
  logic [31:0] align_wdata, align_load;
  logic [3:0]  align_be;

  assign busy       = (state_q == StBusy);
  assign mem_op     = !control_in[CtrlBubble] &&
                      (control_in[CtrlMemRead] || control_in[CtrlMemWrite]);
  assign misaligned = !is_byte_size(control_in[CtrlSizeHi:CtrlSizeLo]) && (alu_in[1:0] != 2'b00);

  // Live inputs steer stores at issue; latched values drive load extraction at ack.
  assign align_size = busy ? ctrl_q[CtrlSizeHi:CtrlSizeLo] : control_in[CtrlSizeHi:CtrlSizeLo];
  assign align_lane = busy ? alu_q[1:0] : alu_in[1:0];

  mem_align u_mem_align (
    .size       (align_size),
    .lane       (align_lane),
    .store_data (sw_in),
    .rdata      (dmem_rdata),
    .wdata      (align_wdata),
    .be         (align_be),
    .load_data  (align_load)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    ctrl_d      = ctrl_q;
    regdst_d    = regdst_q;
    alu_d       = alu_q;
    misalign_d  = 1'b0;
    wb_ctrl_d   = BUBBLE_CTRL;
    wb_data_d   = '0;
    wb_regdst_d = '0;
    stall_out   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_op && misaligned) begin
          misalign_d = 1'b1;
        end else if (mem_op) begin
          stall_out = 1'b1;
          state_d   = StBusy;
          req_d     = 1'b1;
          we_d      = control_in[CtrlMemWrite];
          addr_d    = {alu_in[ADDR_W-1:2], 2'b00};
          wdata_d   = align_wdata;
          be_d      = align_be;
          ctrl_d    = control_in;
          regdst_d  = regdst_in;
          alu_d     = alu_in;
        end else begin
          wb_ctrl_d   = control_in;
          wb_data_d   = control_in[CtrlLink] ? pc_4_in : alu_in;
          wb_regdst_d = regdst_in;
        end
      end
      StBusy: begin
        stall_out = !dmem_ack;
        if (dmem_ack) begin
          req_d       = 1'b0;
          state_d     = StIdle;
          wb_ctrl_d   = ctrl_q;
          wb_regdst_d = regdst_q;
          wb_data_d   = (ctrl_q[CtrlMemRead] && !ctrl_q[CtrlMemWrite]) ? align_load : alu_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      misalign_q  <= 1'b0;
      ctrl_q      <= BUBBLE_CTRL;
      regdst_q    <= '0;
      alu_q       <= '0;
      wb_ctrl_q   <= BUBBLE_CTRL;
      wb_data_q   <= '0;
      wb_regdst_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      misalign_q  <= misalign_d;
      ctrl_q      <= ctrl_d;
      regdst_q    <= regdst_d;
      alu_q       <= alu_d;
      wb_ctrl_q   <= wb_ctrl_d;
      wb_data_q   <= wb_data_d;
      wb_regdst_q <= wb_regdst_d;
    end
  end

  assign misalign_out   = misalign_q;
  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign dmem_be        = be_q;
  assign wb_control_out = wb_ctrl_q;
  assign wb_data_out    = wb_data_q;
  assign wb_regdst_out  = wb_regdst_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-cycle vectors plus hand-written memory
// transactions and a reset-during-access sequence.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  control_in;
  logic [31:0] pc_4_in, alu_in, sw_in;
  logic [4:0]  regdst_in;
  logic        stall_out, misalign_out, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, wb_data_out;
  logic [3:0]  dmem_be;
  logic [7:0]  wb_control_out;
  logic [4:0]  wb_regdst_out;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk            (clk),
    .reset          (reset),
    .control_in     (control_in),
    .pc_4_in        (pc_4_in),
    .alu_in         (alu_in),
    .sw_in          (sw_in),
    .regdst_in      (regdst_in),
    .stall_out      (stall_out),
    .misalign_out   (misalign_out),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_be        (dmem_be),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata),
    .wb_control_out (wb_control_out),
    .wb_data_out    (wb_data_out),
    .wb_regdst_out  (wb_regdst_out)
  );

  typedef struct {
    logic [7:0]  ctrl;
    logic [31:0] pc4;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        ack;
    logic        exp_stall;
    logic        exp_mis;
    logic [7:0]  exp_wbc;
    logic [31:0] exp_wbd;
    logic [4:0]  exp_wbr;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] c, input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] s, input logic [4:0] r);
    control_in = c;
    pc_4_in    = p;
    alu_in     = a;
    sw_in      = s;
    regdst_in  = r;
  endtask

  task automatic mem_txn(input string name, input logic [7:0] c, input logic [31:0] a,
                         input logic [31:0] s, input logic [4:0] r, input int waits,
                         input logic [31:0] rdata, input logic exp_we, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_wbd);
    @(negedge clk);
    drive(c, 32'h0, a, s, r);
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    #1 check({name, " issue stall"}, stall_out, 1'b1);
    @(posedge clk);
    #1;
    check({name, " req"}, dmem_req, 1'b1);
    check({name, " we"}, dmem_we, exp_we);
    check({name, " addr"}, dmem_addr, a & 32'hFFFF_FFFC);
    check({name, " be"}, dmem_be, exp_be);
    check({name, " wdata"}, dmem_wdata, exp_wdata);
    check({name, " wb bubble"}, wb_control_out, 8'h01);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      #1 check({name, " wait stall"}, stall_out, 1'b1);
      @(posedge clk);
      #1;
      check({name, " wait req held"}, dmem_req, 1'b1);
      check({name, " wait addr held"}, dmem_addr, a & 32'hFFFF_FFFC);
      check({name, " wait wb bubble"}, wb_control_out, 8'h01);
    end
    @(negedge clk);
    dmem_ack   = 1'b1;
    dmem_rdata = rdata;
    #1 check({name, " ack stall"}, stall_out, 1'b0);
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    check({name, " req drop"}, dmem_req, 1'b0);
    check({name, " wb ctrl"}, wb_control_out, c);
    check({name, " wb data"}, wb_data_out, exp_wbd);
    check({name, " wb rd"}, wb_regdst_out, r);
    @(negedge clk);
    drive(8'h01, 32'h0, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    //        ctrl   pc4         alu           rd  ack stl mis wbc    wbd           wbr
    vecs[0] = '{8'h08, 32'h104, 32'h0000_1234, 5'd5,  0, 0, 0, 8'h08, 32'h0000_1234, 5'd5};
    vecs[1] = '{8'h1A, 32'h0,   32'h0000_0101, 5'd7,  0, 0, 1, 8'h01, 32'h0,         5'd0};
    vecs[2] = '{8'h28, 32'h200, 32'h0000_0055, 5'd31, 0, 0, 0, 8'h28, 32'h0000_0200, 5'd31};
    vecs[3] = '{8'hDA, 32'h0,   32'h0000_0102, 5'd6,  0, 0, 1, 8'h01, 32'h0,         5'd0};
    vecs[4] = '{8'h01, 32'h0,   32'h0000_0077, 5'd9,  0, 0, 0, 8'h01, 32'h0000_0077, 5'd9};
    vecs[5] = '{8'h04, 32'h0,   32'h0000_0103, 5'd2,  0, 0, 1, 8'h01, 32'h0,         5'd0};
    vecs[6] = '{8'h07, 32'h0,   32'h0000_0099, 5'd1,  0, 0, 0, 8'h07, 32'h0000_0099, 5'd1};
    vecs[7] = '{8'h08, 32'h0,   32'h0000_CAFE, 5'd3,  1, 0, 0, 8'h08, 32'h0000_CAFE, 5'd3};

    reset      = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    drive(8'h01, 32'h0, 32'h0, 32'h0, 5'd0);
    #12;
    check("reset req", dmem_req, 1'b0);
    check("reset we", dmem_we, 1'b0);
    check("reset addr", dmem_addr, 32'h0);
    check("reset be", dmem_be, 4'h0);
    check("reset misalign", misalign_out, 1'b0);
    check("reset wb ctrl", wb_control_out, 8'h01);
    check("reset wb data", wb_data_out, 32'h0);
    check("reset wb rd", wb_regdst_out, 5'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(vecs[i].ctrl, vecs[i].pc4, vecs[i].alu, 32'h0, vecs[i].rd);
      dmem_ack = vecs[i].ack;
      #1 check($sformatf("vec%0d stall", i), stall_out, vecs[i].exp_stall);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d misalign", i), misalign_out, vecs[i].exp_mis);
      check($sformatf("vec%0d req", i), dmem_req, 1'b0);
      check($sformatf("vec%0d wb ctrl", i), wb_control_out, vecs[i].exp_wbc);
      check($sformatf("vec%0d wb data", i), wb_data_out, vecs[i].exp_wbd);
      check($sformatf("vec%0d wb rd", i), wb_regdst_out, vecs[i].exp_wbr);
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    drive(8'h01, 32'h0, 32'h0, 32'h0, 5'd0);

    mem_txn("lw", 8'h1A, 32'h100, 32'h0, 5'd8, 3, 32'hDEAD_BEEF, 1'b0, 4'hF, 32'h0,
            32'hDEAD_BEEF);
    mem_txn("lb", 8'h5A, 32'h103, 32'h0, 5'd10, 0, 32'h8000_0000, 1'b0, 4'b1000, 32'h0,
            32'hFFFF_FF80);
    mem_txn("lbu", 8'h9A, 32'h103, 32'h0, 5'd11, 1, 32'h8000_0000, 1'b0, 4'b1000, 32'h0,
            32'h0000_0080);
    mem_txn("sb", 8'h44, 32'h102, 32'hAB, 5'd0, 1, 32'h0, 1'b1, 4'b0100, 32'hABAB_ABAB,
            32'h0000_0102);
    mem_txn("sw", 8'h04, 32'h108, 32'h1122_3344, 5'd0, 0, 32'h0, 1'b1, 4'hF, 32'h1122_3344,
            32'h0000_0108);

    // Reset while an access is outstanding.
    @(negedge clk);
    drive(8'h1A, 32'h0, 32'h200, 32'h0, 5'd12);
    @(posedge clk);
    #1 check("rst busy req", dmem_req, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("rst req drop", dmem_req, 1'b0);
    check("rst wb ctrl", wb_control_out, 8'h01);
    check("rst wb data", wb_data_out, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    drive(8'h08, 32'h0, 32'h42, 32'h0, 5'd4);
    #1 check("rst idle stall", stall_out, 1'b0);
    @(posedge clk);
    #1;
    check("rst idle wb data", wb_data_out, 32'h42);
    check("rst idle req", dmem_req, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
